// File: rtl/mem_ctrl.sv
// mem_ctrl: byte load/store front end for a 256x8 ram with
// setup/pulse/hold write timing and a hardware fill engine.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_write_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_F_SETUP,
    S_F_PULSE,
    S_F_HOLD
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // Strobe and pulse registers are set on the edge entering the
  // state they belong to, so every output is a plain flop.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          cnt_d   = '0;
          addr_d  = '0;
          wdata_d = fill_value;
          state_d = S_F_SETUP;
        end else if (cpu_req) begin
          addr_d = cpu_addr;
          if (cpu_we) begin
            wdata_d = cpu_wdata;
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = ram_data;
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_WR_SETUP: begin
        write_d = 1'b1;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        ack_d   = 1'b1;
        state_d = S_WR_HOLD;
      end
      S_WR_HOLD: begin
        state_d = S_IDLE;
      end
      S_F_SETUP: begin
        write_d = 1'b1;
        state_d = S_F_PULSE;
      end
      S_F_PULSE: begin
        done_d  = cnt_last;
        state_d = S_F_HOLD;
      end
      S_F_HOLD: begin
        if (cnt_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          addr_d  = cnt_q + CNT_ONE;
          state_d = S_F_SETUP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cpu_ready      = (state_q == S_IDLE);
    fill_busy      = (state_q == S_F_SETUP) ||
                     (state_q == S_F_PULSE) ||
                     (state_q == S_F_HOLD);
    cpu_ack        = ack_q;
    cpu_rdata      = rdata_q;
    fill_done      = done_q;
    ram_address    = addr_q;
    ram_write      = write_q;
    ram_write_data = wdata_q;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized bench for mem_ctrl with a behavioural
// ram and a reference memory image kept by the bench.
module tb_mem_ctrl;

  logic       clk;
  logic       reset;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ready;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       fill_start;
  logic [7:0] fill_value;
  logic       fill_busy;
  logic       fill_done;
  logic [7:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_write;
  logic [7:0] ram_write_data;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       bk_we;
  logic [7:0] bk_addr;
  logic [7:0] bk_data;

  int tests;
  int fails;
  int viol = 0;
  logic p_rst = 1'b1;
  logic p_wr = 1'b0;
  logic [7:0] p_addr = 8'h00;
  logic [7:0] p_wd = 8'h00;

  localparam logic [28:0] RST_VAL = 29'h1000_0000;

  mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .fill_start(fill_start),
    .fill_value(fill_value),
    .fill_busy(fill_busy),
    .fill_done(fill_done),
    .ram_address(ram_address),
    .ram_data(ram_data),
    .ram_write(ram_write),
    .ram_write_data(ram_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_data = mem[ram_address];

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (ram_write) mem[ram_address] <= ram_write_data;
  end

  // Address/data may only move on edges with the strobe low on both sides.
  always @(negedge clk) begin
    if (!p_rst && (ram_write || p_wr) &&
        (ram_address !== p_addr || ram_write_data !== p_wd))
      viol <= viol + 1;
    p_rst  <= reset;
    p_wr   <= ram_write;
    p_addr <= ram_address;
    p_wd   <= ram_write_data;
  end

  function automatic logic [28:0] outs();
    return {cpu_ready, cpu_ack, fill_busy, fill_done, ram_write,
            ram_address, ram_write_data, cpu_rdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bk_we   = 1'b1;
      bk_addr = 8'(i);
      bk_data = (i == 'hA0) ? 8'h00 : 8'($urandom);
      ref_mem[i] = bk_data;
      tick();
    end
    bk_we = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic load(input logic [7:0] a, output logic [7:0] d,
                      output int lat);
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = a;
    tick();
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_ack && lat < 12) begin
      tick();
      lat++;
    end
    d = cpu_rdata;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d,
                       output int lat, output int wr, output int stab);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    tick();
    cpu_req = 1'b0;
    lat  = 1;
    wr   = 0;
    stab = 1;
    while (!cpu_ack && lat < 12) begin
      if (ram_write) wr++;
      if (ram_address !== a || ram_write_data !== d) stab = 0;
      tick();
      lat++;
    end
    if (ram_write) wr++;
    if (ram_address !== a || ram_write_data !== d) stab = 0;
    ref_mem[a] = d;
    tick();
  endtask

  task automatic test_reset();
    tests++;
    if (outs() !== RST_VAL) begin
      fails++;
      $display("FAIL reset_values: got %h expected %h", outs(), RST_VAL);
    end
  endtask

  task automatic test_first_load();
    int bad;
    int lat;
    logic [7:0] d;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ready !== 1'b1) bad++;
      tick();
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL idle_ready: %0d idle cycles without ready, want 0", bad);
    end
    load(8'hA0, d, lat);
    tests++;
    if (lat !== 2) begin
      fails++;
      $display("FAIL load_latency: got %0d expected 2", lat);
    end
    tests++;
    if (d !== 8'h00 || cpu_ready !== 1'b1) begin
      fails++;
      $display("FAIL first_load: data %h ready %b expected 00 1", d, cpu_ready);
    end
  endtask

  task automatic test_store_load();
    int lat;
    int wr;
    int stab;
    logic [7:0] d;
    logic [7:0] a [2];
    logic [7:0] v [2];
    a[0] = 8'hA0; v[0] = 8'hBE;
    a[1] = 8'hA1; v[1] = 8'hEF;
    for (int i = 0; i < 2; i++) begin
      store(a[i], v[i], lat, wr, stab);
      tests++;
      if (lat !== 3 || wr !== 1 || stab !== 1) begin
        fails++;
        $display("FAIL store_seq %h: ack %0d writes %0d stable %0d expected 3 1 1",
                 a[i], lat, wr, stab);
      end
    end
    tests++;
    if (cpu_rdata !== 8'h00) begin
      fails++;
      $display("FAIL rdata_kept: got %h expected 00", cpu_rdata);
    end
    for (int i = 0; i < 2; i++) begin
      load(a[i], d, lat);
      tests++;
      if (d !== v[i] || lat !== 2) begin
        fails++;
        $display("FAIL store_readback %h: got %h lat %0d expected %h lat 2",
                 a[i], d, lat, v[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    int wr;
    int stab;
    logic [7:0] a;
    logic [7:0] v;
    logic [7:0] d;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      v = 8'($urandom);
      if ($urandom_range(1) == 1) begin
        store(a, v, lat, wr, stab);
        tests++;
        if (lat !== 3 || wr !== 1 || stab !== 1) begin
          fails++;
          $display("FAIL rand_store %h: ack %0d writes %0d stable %0d expected 3 1 1",
                   a, lat, wr, stab);
        end
      end else begin
        load(a, d, lat);
        tests++;
        if (d !== ref_mem[a] || lat !== 2) begin
          fails++;
          $display("FAIL rand_load %h: got %h lat %0d expected %h lat 2",
                   a, d, lat, ref_mem[a]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [4];
    logic [7:0] got [4];
    int ack_cyc [4];
    int k;
    int n;
    int cyc;
    logic acc;
    for (int i = 0; i < 4; i++) a[i] = 8'($urandom);
    k = 0;
    n = 0;
    cyc = 0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = a[0];
    while (n < 4 && cyc < 20) begin
      acc = cpu_ready && cpu_req;
      tick();
      cyc++;
      if (acc) begin
        k++;
        if (k == 4) cpu_req = 1'b0;
        else cpu_addr = a[k];
      end
      if (cpu_ack) begin
        got[n] = cpu_rdata;
        ack_cyc[n] = cyc;
        n++;
      end
    end
    cpu_req = 1'b0;
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d acks expected 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got[i] !== ref_mem[a[i]]) begin
          fails++;
          $display("FAIL b2b_data %0d: got %h expected %h", i, got[i], ref_mem[a[i]]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (ack_cyc[i] - ack_cyc[i-1] !== 2) begin
          fails++;
          $display("FAIL b2b_spacing %0d: got %0d expected 2", i,
                   ack_cyc[i] - ack_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_fill_priority();
    int cyc;
    int busy_bad;
    int ack_bad;
    int bad;
    logic [7:0] x;
    x = 8'($urandom);
    cpu_req    = 1'b1;
    cpu_we     = 1'b0;
    cpu_addr   = x;
    fill_start = 1'b1;
    fill_value = 8'h5A;
    tick();
    fill_start = 1'b0;
    cyc = 1;
    busy_bad = 0;
    ack_bad = 0;
    while (!fill_done && cyc < 1000) begin
      if (!fill_busy) busy_bad++;
      if (cpu_ack) ack_bad++;
      tick();
      cyc++;
    end
    tests++;
    if (cyc !== 768 || !fill_busy || busy_bad !== 0 || ack_bad !== 0) begin
      fails++;
      $display("FAIL fill_timing: done at %0d busy %b gaps %0d acks %0d expected 768 1 0 0",
               cyc, fill_busy, busy_bad, ack_bad);
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h5A;
    tick();
    tests++;
    if (cpu_ready !== 1'b1 || fill_busy !== 1'b0 || fill_done !== 1'b0) begin
      fails++;
      $display("FAIL fill_end: ready %b busy %b done %b expected 1 0 0",
               cpu_ready, fill_busy, fill_done);
    end
    tick();
    cpu_req = 1'b0;
    tick();
    tests++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A) begin
      fails++;
      $display("FAIL held_req: ack %b data %h expected 1 5a", cpu_ack, cpu_rdata);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL fill_contents: %0d locations differ from 5a, want 0", bad);
    end
  endtask

  task automatic test_reset_wr_pulse();
    int acks;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 8'h10;
    cpu_wdata = 8'h33;
    tick();
    cpu_req = 1'b0;
    tick();
    tests++;
    if (ram_write !== 1'b1) begin
      fails++;
      $display("FAIL wr_pulse_reached: ram_write %b expected 1", ram_write);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_mem[8'h10] = 8'h33;
    tests++;
    if (outs() !== RST_VAL) begin
      fails++;
      $display("FAIL reset_in_store: got %h expected %h", outs(), RST_VAL);
    end
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (cpu_ack) acks++;
      tick();
    end
    tests++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL dropped_ack: got %0d acks expected 0", acks);
    end
  endtask

  task automatic test_reset_fill();
    int cyc;
    int bad;
    int dones;
    fill_start = 1'b1;
    fill_value = 8'h00;
    tick();
    fill_start = 1'b0;
    cyc = 1;
    while (!fill_done && cyc < 1000) begin
      tick();
      cyc++;
    end
    tick();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    tests++;
    if (bad !== 0 || cyc !== 768) begin
      fails++;
      $display("FAIL zero_fill: %0d bad locations done at %0d expected 0 768", bad, cyc);
    end
    fill_start = 1'b1;
    fill_value = 8'hFF;
    tick();
    fill_start = 1'b0;
    dones = 0;
    for (int i = 1; i < 100; i++) begin
      if (fill_done) dones++;
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (outs() !== RST_VAL) begin
      fails++;
      $display("FAIL reset_in_fill: got %h expected %h", outs(), RST_VAL);
    end
    for (int i = 0; i < 10; i++) begin
      if (fill_done || fill_busy) dones++;
      tick();
    end
    tests++;
    if (dones !== 0) begin
      fails++;
      $display("FAIL abandoned_fill: %0d busy/done cycles expected 0", dones);
    end
    for (int i = 0; i <= 'h20; i++) ref_mem[i] = 8'hFF;
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (i != 'h21 && mem[i] !== ref_mem[i]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL partial_fill: %0d locations wrong expected 0", bad);
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (viol !== 0) begin
      fails++;
      $display("FAIL addr_stability: %0d changes next to strobe expected 0", viol);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    reset      = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = 8'h00;
    cpu_wdata  = 8'h00;
    fill_start = 1'b0;
    fill_value = 8'h00;
    bk_we      = 1'b0;
    bk_addr    = 8'h00;
    bk_data    = 8'h00;
    preload();
    test_reset();
    test_first_load();
    test_store_load();
    test_random();
    test_back_to_back();
    test_fill_priority();
    test_reset_wr_pulse();
    test_reset_fill();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
